id_ex_stage_reg: RTL
====================

# id_ex_stage_reg

Pipeline register between the decode stage and the execute stage of the ARM core. It captures the decoded control word, both register-file operands, the immediate/shift fields, the destination and source register numbers, and the status flags on every rising clock edge. It supports memory-stall freeze, branch flush and hazard bubble insertion. It also keeps a saturating count of inserted bubbles for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the bubble counter

Ports:
- clk  in  1  clock; the register updates on the rising edge (the register file writes on the falling edge)
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  memory stall; hold every output
- flush  in  1  branch taken in EX; load a NOP
- hazard  in  1  data hazard in decode; load a bubble
- pc_in / pc_out  in/out  32  instruction PC+4
- wb_en_in / wb_en_out  in/out  1  writeback enable
- mem_r_en_in / mem_r_en_out  in/out  1  load
- mem_w_en_in / mem_w_en_out  in/out  1  store
- b_in / b_out  in/out  1  branch
- s_in / s_out  in/out  1  update status
- exe_cmd_in / exe_cmd_out  in/out  4  ALU command
- imm_in / imm_out  in/out  1  immediate operand select
- val_rn_in / val_rn_out  in/out  32  register file reg1
- val_rm_in / val_rm_out  in/out  32  register file reg2
- shift_operand_in / shift_operand_out  in/out  12  shifter operand
- signed_imm_24_in / signed_imm_24_out  in/out  24  branch offset
- dest_in / dest_out  in/out  4  destination register
- src1_in / src1_out, src2_in / src2_out  in/out  4  source register numbers (for forwarding)
- status_in / status_out  in/out  4  NZCV flags
- valid_out  out  1  the EX stage holds a real instruction
- bubble_count  out  CNT_W  number of bubbles inserted since reset

## Operation
Each rising edge applies exactly one action. Priority is rst > freeze > flush > hazard > load.
- rst: all outputs go to 0, including valid_out and bubble_count.
- freeze=1: every output, including bubble_count, holds. flush and hazard are ignored; the EX stage re-asserts flush after the stall ends.
- flush=1 (freeze=0): NOP is loaded.
  - All control bits go to 0: wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd=0.
  - valid_out=0.
  - All data fields go to 0.
  - bubble_count does not increment.
- hazard=1 (freeze=0, flush=0): a bubble is loaded. It is identical to the NOP, and bubble_count increments.
- Otherwise: every *_in is copied to *_out and valid_out=1.
- bubble_count saturates at 2^CNT_W−1 and never wraps.
- Control outputs are 0 whenever valid_out=0. This guarantees a bubble has no side effects: no writeback, no memory access, no branch, no flag update.
- The block does no combinational path from input to output; all outputs are registered.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Reset is asynchronous. Outputs clear immediately when rst rises, and the first load happens on the first rising edge after rst falls.
- freeze held for k cycles: the outputs stay constant for k edges, and the next unfrozen edge applies the normal priority.
- flush and hazard in the same cycle: flush wins and the counter is unchanged.
- Back-to-back hazards: each cycle inserts one bubble and adds 1 to the count.
- Reset in the middle of a freeze or of a counting sequence clears everything. No state survives reset.

## Test plan
- Reset: drive all inputs to 1s, pulse rst asynchronously between edges → all outputs 0 immediately, and valid_out=0.
- Normal load: pc_in=0x104, wb_en_in=1, exe_cmd_in=4'b0010, val_rn_in=0xDEADBEEF, dest_in=3 → after one edge the outputs match and valid_out=1.
- Freeze: load an instruction, then freeze=1 for 3 cycles with new inputs and flush=1 → outputs unchanged for 3 edges, and bubble_count unchanged.
- Flush vs hazard: flush=1 and hazard=1 together → NOP (wb_en_out=0, mem_w_en_out=0, valid_out=0), bubble_count unchanged. hazard alone for 2 cycles → bubble_count +2.
- Saturation: set CNT_W=2 and hold hazard for 5 cycles → bubble_count goes 1,2,3,3,3.
- Bubble side effects: hazard with mem_w_en_in=1, s_in=1, b_in=1 → all three outputs 0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded control, operands and flags each cycle,
// with stall freeze, flush/bubble NOP insertion and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             hazard,
  input  logic [31:0]      pc_in,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic             imm_in,
  input  logic [31:0]      val_rn_in,
  input  logic [31:0]      val_rm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm_24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       status_in,
  output logic [31:0]      pc_out,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic [3:0]       exe_cmd_out,
  output logic             imm_out,
  output logic [31:0]      val_rn_out,
  output logic [31:0]      val_rm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm_24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       status_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        b;
    logic        s;
    logic [3:0]  exe_cmd;
    logic        imm;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  status;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  stage_t           d;
  stage_t           q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  assign d = '{
    pc:            pc_in,
    wb_en:         wb_en_in,
    mem_r_en:      mem_r_en_in,
    mem_w_en:      mem_w_en_in,
    b:             b_in,
    s:             s_in,
    exe_cmd:       exe_cmd_in,
    imm:           imm_in,
    val_rn:        val_rn_in,
    val_rm:        val_rm_in,
    shift_operand: shift_operand_in,
    signed_imm_24: signed_imm_24_in,
    dest:          dest_in,
    src1:          src1_in,
    src2:          src2_in,
    status:        status_in
  };

  // A NOP/bubble is the all-zero word, so every control bit is 0 while valid_q is 0.
  // NOTE: non-blocking assignments for all state; rst is in the sensitivity list so it clears without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (!freeze) begin
      if (flush || hazard) begin
        q       <= '0;
        valid_q <= 1'b0;
        if (!flush && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_ONE;
      end else begin
        q       <= d;
        valid_q <= 1'b1;
      end
    end
  end

  assign pc_out            = q.pc;
  assign wb_en_out         = q.wb_en;
  assign mem_r_en_out      = q.mem_r_en;
  assign mem_w_en_out      = q.mem_w_en;
  assign b_out             = q.b;
  assign s_out             = q.s;
  assign exe_cmd_out       = q.exe_cmd;
  assign imm_out           = q.imm;
  assign val_rn_out        = q.val_rn;
  assign val_rm_out        = q.val_rm;
  assign shift_operand_out = q.shift_operand;
  assign signed_imm_24_out = q.signed_imm_24;
  assign dest_out          = q.dest;
  assign src1_out          = q.src1;
  assign src2_out          = q.src2;
  assign status_out        = q.status;
  assign valid_out         = valid_q;
  assign bubble_count      = cnt_q;

endmodule
